// File: rtl/cic_interp_var.sv
// cic_interp_var: runtime-rate complex CIC interpolator with rounding, saturation and flush on rate change
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   clock_en            one output sample per enabled cycle
//   rate                requested interpolation, clamped to [2, RMAX]
//   x_real, x_imag      input sample, consumed at each wrap event
//   req                 one-cycle strobe after an input is consumed
//   y_real, y_imag      rounded, saturated output sample
//   y_valid             one-cycle strobe after each enabled cycle

module cic_interp_chan #(
    parameter int STAGES = 5,
    parameter int IBITS  = 20,
    parameter int OBITS  = 16,
    parameter int GBITS  = 34,
    localparam int CBITS = IBITS + GBITS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clock_en,
    input  logic                    wrap,
    input  logic                    flush,
    input  logic signed [IBITS-1:0] x,
    output logic signed [OBITS-1:0] y
);
    // stg[0] is the captured input x0; stg[1..N-1] are comb stages; co is stage N,
    // zero-stuffed on non-wrap cycles.
    logic signed [CBITS-1:0] stg   [STAGES];
    logic signed [CBITS-1:0] dly   [STAGES];
    logic signed [CBITS-1:0] integ [STAGES];
    logic signed [CBITS-1:0] co;
    logic signed [CBITS-1:0] xs;
    logic        [OBITS-1:0] top;
    logic                    rnd;
    logic signed [OBITS-1:0] v;

    assign xs  = {{GBITS{x[IBITS-1]}}, x};
    assign top = integ[STAGES-1][CBITS-1 -: OBITS];

    generate
        if (CBITS > OBITS) begin : g_rnd
            assign rnd = integ[STAGES-1][CBITS-OBITS-1];
        end else begin : g_nornd
            assign rnd = 1'b0;
        end
    endgenerate

    // Only the largest positive value can overflow when the half-LSB is added.
    assign v = (rnd && top == {1'b0, {(OBITS-1){1'b1}}}) ? top : top + OBITS'(rnd);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stg[k]   <= '0;
                dly[k]   <= '0;
                integ[k] <= '0;
            end
            co <= '0;
            y  <= '0;
        end else if (flush) begin
            for (int k = 0; k < STAGES; k++) begin
                stg[k]   <= '0;
                dly[k]   <= '0;
                integ[k] <= '0;
            end
            stg[0] <= xs;
            co     <= '0;
        end else if (clock_en) begin
            if (wrap) begin
                stg[0] <= xs;
                for (int k = 1; k < STAGES; k++)
                    stg[k] <= stg[k-1] - dly[k-1];
                for (int k = 0; k < STAGES; k++)
                    dly[k] <= stg[k];
                co <= stg[STAGES-1] - dly[STAGES-1];
            end else begin
                co <= '0;
            end
            integ[0] <= integ[0] + co;
            for (int k = 1; k < STAGES; k++)
                integ[k] <= integ[k] + integ[k-1];
            y <= v;
        end
    end
endmodule

module cic_interp_var #(
    parameter int STAGES = 5,
    parameter int RMAX   = 320,
    parameter int IBITS  = 20,
    parameter int OBITS  = 16,
    parameter int GBITS  = 34,
    localparam int RBITS = $clog2(RMAX + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clock_en,
    input  logic [RBITS-1:0]        rate,
    input  logic signed [IBITS-1:0] x_real,
    input  logic signed [IBITS-1:0] x_imag,
    output logic                    req,
    output logic signed [OBITS-1:0] y_real,
    output logic signed [OBITS-1:0] y_imag,
    output logic                    y_valid
);
    logic [RBITS-1:0] cnt;
    logic [RBITS-1:0] rate_active;
    logic [RBITS-1:0] rc;
    logic             wrap;
    logic             flush;

    assign rc    = (rate < RBITS'(2)) ? RBITS'(2) : (rate > RBITS'(RMAX)) ? RBITS'(RMAX) : rate;
    assign wrap  = clock_en && (cnt == rate_active - RBITS'(1));
    assign flush = wrap && (rc != rate_active);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            rate_active <= rc;
            req         <= 1'b0;
            y_valid     <= 1'b0;
        end else begin
            req     <= wrap;
            y_valid <= clock_en;
            if (clock_en)
                cnt <= wrap ? '0 : cnt + RBITS'(1);
            if (flush)
                rate_active <= rc;
        end
    end

    cic_interp_chan #(.STAGES(STAGES), .IBITS(IBITS), .OBITS(OBITS), .GBITS(GBITS)) u_real (
        .clock(clock), .reset(reset), .clock_en(clock_en), .wrap(wrap), .flush(flush),
        .x(x_real), .y(y_real)
    );

    cic_interp_chan #(.STAGES(STAGES), .IBITS(IBITS), .OBITS(OBITS), .GBITS(GBITS)) u_imag (
        .clock(clock), .reset(reset), .clock_en(clock_en), .wrap(wrap), .flush(flush),
        .x(x_imag), .y(y_imag)
    );
endmodule

// File: tb/tb_cic_interp_var.sv
// tb_cic_interp_var: directed self-checking bench for cic_interp_var
module tb_cic_interp_var;
    localparam int STAGES = 5;
    localparam int RMAX   = 320;
    localparam int IBITS  = 12;
    localparam int OBITS  = 12;
    localparam int GBITS  = 4;
    localparam int RBITS  = $clog2(RMAX + 1);

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    clock_en = 1'b0;
    logic [RBITS-1:0]        rate = RBITS'(2);
    logic signed [IBITS-1:0] x_real = '0;
    logic signed [IBITS-1:0] x_imag = '0;
    logic                    req;
    logic signed [OBITS-1:0] y_real;
    logic signed [OBITS-1:0] y_imag;
    logic                    y_valid;

    int tests = 0;
    int fails = 0;
    int yr [128];
    int yi [128];
    int rq [128];
    int yv [128];
    int imp_r [6]  = '{1, 5, 10, 10, 5, 1};
    int imp_i [6]  = '{1, 3, 5, 5, 3, 1};
    int sat_r [11] = '{46, 228, 683, 1365, 2047, -1775, 2047, 1365, 683, 228, 46};

    cic_interp_var #(.STAGES(STAGES), .RMAX(RMAX), .IBITS(IBITS), .OBITS(OBITS), .GBITS(GBITS)) dut (
        .clock(clock), .reset(reset), .clock_en(clock_en), .rate(rate),
        .x_real(x_real), .x_imag(x_imag), .req(req),
        .y_real(y_real), .y_imag(y_imag), .y_valid(y_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int r);
        rate     = RBITS'(r);
        x_real   = '0;
        x_imag   = '0;
        clock_en = 1'b1;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Edge n (1-based) counts enabled edges after reset release; the input is held
    // through the first wrap (edge r) and cleared once req has been seen.
    task automatic capture(input int r, input int xr, input int xi, input int n);
        do_reset(r);
        x_real = IBITS'(xr);
        x_imag = IBITS'(xi);
        for (int k = 1; k <= n; k++) begin
            if (k == r + 1) begin
                x_real = '0;
                x_imag = '0;
            end
            tick();
            yr[k] = int'(y_real);
            yi[k] = int'(y_imag);
            rq[k] = int'(req);
            yv[k] = int'(y_valid);
        end
    endtask

    task automatic req_period(input int r, input int ncyc, input int exp_first, input int exp_cnt);
        int first;
        int cnt;
        first = 0;
        cnt   = 0;
        do_reset(r);
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            if (req) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
        check($sformatf("clamp_first_req_rate%0d", r), first, exp_first);
        check($sformatf("clamp_req_count_rate%0d", r), cnt, exp_cnt);
    endtask

    initial begin
        int e;
        reset    = 1'b1;
        clock_en = 1'b1;
        x_real   = IBITS'(500);
        tick();
        tick();
        check("rst_y_real", int'(y_real), 0);
        check("rst_y_imag", int'(y_imag), 0);
        check("rst_req", int'(req), 0);
        check("rst_y_valid", int'(y_valid), 0);

        capture(2, 16, 0, 26);
        for (int n = 1; n <= 26; n++) begin
            check($sformatf("imp_y_real@%0d", n), yr[n], (n >= 18 && n <= 23) ? imp_r[n-18] : 0);
            check($sformatf("imp_y_imag@%0d", n), yi[n], 0);
            check($sformatf("imp_req@%0d", n), rq[n], int'(n % 2 == 0));
            check($sformatf("imp_y_valid@%0d", n), yv[n], 1);
        end

        capture(2, 0, 8, 26);
        for (int n = 1; n <= 26; n++) begin
            check($sformatf("rnd_y_imag@%0d", n), yi[n], (n >= 18 && n <= 23) ? imp_i[n-18] : 0);
            check($sformatf("rnd_y_real@%0d", n), yr[n], 0);
        end

        capture(3, 728, 0, 36);
        for (int n = 20; n <= 36; n++)
            check($sformatf("sat_y_real@%0d", n), yr[n], (n >= 24 && n <= 34) ? sat_r[n-24] : 0);

        capture(2, 16, 0, 19);
        check("mid_pre_y18", yr[18], 1);
        check("mid_pre_y19", yr[19], 5);
        reset = 1'b1;
        tick();
        check("mid_rst_y_real", int'(y_real), 0);
        check("mid_rst_req", int'(req), 0);
        check("mid_rst_y_valid", int'(y_valid), 0);
        reset = 1'b0;
        capture(2, 16, 0, 26);
        for (int n = 1; n <= 26; n++)
            check($sformatf("mid_imp_y_real@%0d", n), yr[n], (n >= 18 && n <= 23) ? imp_r[n-18] : 0);

        do_reset(2);
        x_real = IBITS'(1000);
        x_imag = IBITS'(-2048);
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n >= 59) begin
                check($sformatf("dc_y_real@%0d", n), int'(y_real), 1000);
                check($sformatf("dc_y_imag@%0d", n), int'(y_imag), -2048);
            end
        end
        rate   = RBITS'(4);
        x_imag = '0;
        for (int n = 61; n <= 90; n++) begin
            tick();
            check($sformatf("rchg_req@%0d", n), int'(req), int'(n >= 62 && (n - 62) % 4 == 0));
            check($sformatf("rchg_y_valid@%0d", n), int'(y_valid), 1);
            if (n <= 88)
                check($sformatf("rchg_y_real@%0d", n), int'(y_real), (n <= 62) ? 1000 : (n == 88) ? 63 : 0);
            check($sformatf("rchg_y_imag@%0d", n), int'(y_imag), (n <= 62) ? -2048 : 0);
        end

        do_reset(5);
        e = 0;
        for (int k = 0; k < 45; k++) begin
            clock_en = (k % 3 == 0);
            tick();
            if (k % 3 == 0) e++;
            check($sformatf("hs_y_valid@%0d", k), int'(y_valid), int'(k % 3 == 0));
            check($sformatf("hs_req@%0d", k), int'(req), int'(k % 3 == 0 && e % 5 == 0));
        end
        clock_en = 1'b1;

        req_period(0, 10, 2, 5);
        req_period(RMAX + 7, 700, 320, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cic_interp_var.md
# cic_interp_var

Runtime-rate, parametrised-order complex CIC interpolator for the transmit chain. It takes I/Q samples from the upstream polyphase FIR and requests a new one every `rate` output enables. It then emits one interpolated I/Q sample per `clock_en` toward the DUC mixer. It adds the following: a synchronous reset, a runtime rate with a clean flush on rate change, round-half-up output with saturation, and an output-valid strobe.

## Interface
- STAGES, 5: CIC order N, legal 3..6.
- RMAX, 320: maximum interpolation; sizes the counter (RBITS = clog2(RMAX+1)).
- IBITS, 20: input sample width.
- OBITS, 16: output sample width, must be ≤ CBITS.
- GBITS, 34: growth bits, ≥ ceil((STAGES-1)·log2(RMAX)); CBITS = IBITS+GBITS.
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- clock_en  in  1  one output sample is produced on each cycle this is high.
- rate  in  RBITS  requested interpolation; clamped to [2, RMAX].
- x_real, x_imag  in  IBITS signed  input sample, held until the cycle after req.
- req  out  1  one-cycle strobe: input consumed, present the next sample.
- y_real, y_imag  out  OBITS signed  output sample.
- y_valid  out  1  one-cycle strobe: y_* updated this cycle.

## Operation
- Registers: phase counter, rate_active, and per channel: x0, N comb stages with delays, N integrators, and an output register. Both channels use identical logic.
- Wrap event = clock_en & (counter == rate_active-1). On a wrap event:
  - counter ← 0
  - x0 ← sign-extended input
  - comb stage k ← c(k-1) − d(k-1), d(k-1) ← c(k-1)
  - comb output ← stage N
  - req ← 1
- Non-wrap clock_en cycle: counter+1, comb output ← 0 (zero stuffing), req ← 0.
- Every clock_en cycle, integrators update in a chain: i1 ← i1 + comb_out, ik ← ik + i(k−1).
- All state arithmetic is CBITS two's complement. Wrap-around is intentional and must not be saturated.
- Output reduction on every clock_en:
  - v = i_N[CBITS-1 -: OBITS] + i_N[CBITS-OBITS-1], i.e. round half up. The round bit is 0 when OBITS == CBITS.
  - If the rounding increment overflows the positive limit, the result saturates to 2^(OBITS-1)−1.
  - y ← v, y_valid ← 1.
- Rate clamp: rc = 2 if rate < 2; rc = RMAX if rate > RMAX; otherwise rc = rate.
- Rate change: at a wrap event with rc ≠ rate_active:
  - rate_active ← rc
  - all comb, delay and integrator registers are cleared
  - x0 still captures the current input, and req still pulses
  - the output register keeps its last value, and y_valid still pulses
- clock_en low: no state change; req = 0 and y_valid = 0.
- Gain is rate^(N-1) and the output scaling is fixed for RMAX. Gain compensation is done downstream.

## Timing
- Reset (overrides clock_en):
  - counter = 0, rate_active = rc(rate)
  - all datapath registers = 0
  - req = 0, y_valid = 0, y_real = y_imag = 0
- First wrap event after reset occurs on the rate_active-th clock_en.
- req is high in the cycle after a wrap event, for exactly 1 cycle. The upstream block must change x_* no later than the next wrap event.
- y_valid is high the cycle after each clock_en.
- Impulse captured at wrap event E0 first reaches i1 at event E0 + N·rate_active + 1. The first nonzero y appears after event E0 + N·rate_active + N + 1.
- clock_en back-to-back or sparse: the counter counts enabled cycles only.
- Reset asserted mid-frame: takes effect on that clock edge; no req or y_valid is issued that cycle.

## Test plan
All scenarios use bench parameters IBITS=12, GBITS=4, OBITS=12, STAGES=5 (CBITS=16, shift 4), with clock_en=1 unless stated.
- Impulse, rate=2, x_real=16 for one sample then 0 → y_real nonzero sequence is 1,5,10,10,5,1, then 0. Latency matches the Timing section exactly.
- Rounding, rate=2, x_imag=8 impulse → y_imag is 1,3,5,5,3,1 (half-up); y_real stays 0.
- DC, rate=2: x=1000 → y settles at 1000. x=−2048 → y settles at −2048 with no wrap artefacts.
- Handshake: rate=5, clock_en high 1 of every 3 cycles → req exactly once per 5 enabled cycles, y_valid once per enable, no activity otherwise. rate=0 behaves as 2; rate=RMAX+7 behaves as RMAX.
- Rate change mid-stream, DC x=1000, rate 2→4 → state flushes at the next wrap event; output transitions from 1000 toward 1000·4^4/16 with no stale residue.
- Reset pulsed mid-impulse → every output is 0 next cycle, and the following impulse reproduces the scenario-1 sequence exactly.
